// File: rtl/lomo_frame_sequencer_if.sv
// Word fetch handshake between the frame sequencer (master) and the frame word
// multiplexer (slave): registered request with index, acknowledge with data.
interface lomo_frame_sequencer_if #(
  parameter int W = 16
);
  logic         word_req;
  logic [4:0]   word_idx;
  logic [W-1:0] word_data;
  logic         word_ack;

  modport master (
    output word_req,
    output word_idx,
    input  word_data,
    input  word_ack
  );

  modport slave (
    input  word_req,
    input  word_idx,
    output word_data,
    output word_ack
  );
endinterface

// File: rtl/lomo_frame_sequencer.sv
// LOMO serial frame sequencer: derives the line clock from the sync strobe and
// shifts each string's words MSB first, prefetching one word over the fetch handshake.
module lomo_frame_sequencer #(
  parameter int WORDS_PER_STR = 20,
  parameter int BITS_PER_WORD = 16,
  parameter int STR_W         = 6,
  parameter int FRM_W         = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  sync,
  lomo_frame_sequencer_if.master wbus,
  output logic [STR_W-1:0]      str_num,
  output logic [FRM_W-1:0]      frm_num,
  output logic                  MK,
  output logic                  CLK,
  output logic                  DAT,
  output logic                  busy,
  output logic                  underrun
);

  typedef enum logic [1:0] {IDLE, FETCH0, SHIFT} state_t;

  localparam int                CNT_W    = $clog2(BITS_PER_WORD);
  localparam logic [4:0]        LAST_IDX = 5'(WORDS_PER_STR - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(BITS_PER_WORD - 1);

  state_t                   state_q, state_d;
  logic [2:0]               sync_q, sync_d;
  logic                     clk_q, clk_d;
  logic                     dat_q, dat_d;
  logic                     mk_q, mk_d;
  logic                     und_q, und_d;
  logic [BITS_PER_WORD-1:0] sh_q, sh_d;
  logic [BITS_PER_WORD-1:0] buf_q, buf_d;
  logic                     buf_vld_q, buf_vld_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [4:0]               cur_idx_q, cur_idx_d;
  logic [4:0]               idx_q, idx_d;
  logic                     req_q, req_d;
  logic                     pend_q, pend_d;
  logic [STR_W-1:0]         str_q, str_d;
  logic [FRM_W-1:0]         frm_q, frm_d;
  logic [BITS_PER_WORD-1:0] load_word;
  logic                     front;
  logic                     ack;

  function automatic logic [4:0] next_idx(input logic [4:0] i);
    return (i == LAST_IDX) ? 5'd0 : i + 5'd1;
  endfunction

  assign front = sync_q[1] & ~sync_q[2];
  assign ack   = req_q & wbus.word_ack;

  always_comb begin
    state_d   = state_q;
    sync_d    = {sync_q[1:0], sync};
    clk_d     = clk_q;
    dat_d     = dat_q;
    mk_d      = mk_q;
    und_d     = 1'b0;
    sh_d      = sh_q;
    buf_d     = buf_q;
    buf_vld_d = buf_vld_q;
    cnt_d     = cnt_q;
    cur_idx_d = cur_idx_q;
    idx_d     = idx_q;
    req_d     = req_q;
    pend_d    = pend_q;
    str_d     = str_q;
    frm_d     = frm_q;
    load_word = '0;

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = FETCH0;
          idx_d   = 5'd0;
          req_d   = 1'b1;
        end
      end

      FETCH0: begin
        if (ack) begin
          sh_d      = wbus.word_data;
          dat_d     = wbus.word_data[BITS_PER_WORD-1];
          mk_d      = 1'b1;
          cnt_d     = LAST_BIT;
          cur_idx_d = 5'd0;
          req_d     = 1'b0;
          pend_d    = 1'b1;
          idx_d     = next_idx(5'd0);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Every load drops the request for one cycle, then asks for the following word.
        if (pend_q) begin
          req_d  = 1'b1;
          pend_d = 1'b0;
        end
        if (ack) begin
          buf_d     = wbus.word_data;
          buf_vld_d = 1'b1;
          req_d     = 1'b0;
        end
        if (front) begin
          if (!clk_q) begin
            clk_d = 1'b1;
          end else begin
            clk_d = 1'b0;
            if (cnt_q != '0) begin
              sh_d  = sh_q << 1;
              dat_d = sh_q[BITS_PER_WORD-2];
              cnt_d = cnt_q - 1'b1;
            end else begin
              if (cur_idx_q == LAST_IDX) begin
                str_d = str_q + 1'b1;
                if (&str_q) frm_d = frm_q + 1'b1;
              end
              if ((cur_idx_q == LAST_IDX) && !en) begin
                state_d   = IDLE;
                dat_d     = 1'b0;
                mk_d      = 1'b0;
                buf_vld_d = 1'b0;
                req_d     = 1'b0;
                pend_d    = 1'b0;
                cur_idx_d = 5'd0;
              end else begin
                // An acknowledge landing on the boundary itself feeds the shifter directly.
                if (buf_vld_q) begin
                  load_word = buf_q;
                end else if (ack) begin
                  load_word = wbus.word_data;
                end else begin
                  load_word = '0;
                  und_d     = 1'b1;
                end
                sh_d      = load_word;
                dat_d     = load_word[BITS_PER_WORD-1];
                mk_d      = (next_idx(cur_idx_q) == 5'd0);
                cnt_d     = LAST_BIT;
                cur_idx_d = next_idx(cur_idx_q);
                buf_vld_d = 1'b0;
                req_d     = 1'b0;
                pend_d    = 1'b1;
                idx_d     = next_idx(next_idx(cur_idx_q));
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      clk_q     <= 1'b0;
      dat_q     <= 1'b0;
      mk_q      <= 1'b0;
      und_q     <= 1'b0;
      sh_q      <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      cnt_q     <= '0;
      cur_idx_q <= '0;
      idx_q     <= '0;
      req_q     <= 1'b0;
      pend_q    <= 1'b0;
      str_q     <= '0;
      frm_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      clk_q     <= clk_d;
      dat_q     <= dat_d;
      mk_q      <= mk_d;
      und_q     <= und_d;
      sh_q      <= sh_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      cnt_q     <= cnt_d;
      cur_idx_q <= cur_idx_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      pend_q    <= pend_d;
      str_q     <= str_d;
      frm_q     <= frm_d;
    end
  end

  assign wbus.word_req = req_q;
  assign wbus.word_idx = idx_q;
  assign str_num       = str_q;
  assign frm_num       = frm_q;
  assign MK            = mk_q;
  assign CLK           = clk_q;
  assign DAT           = dat_q;
  assign busy          = (state_q != IDLE);
  assign underrun      = und_q;

endmodule
